// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared timing constants and enums for the framebuffer SRAM arbiter
package fb_pkg;

    // VGA 640x480 timing and 1 bpp framebuffer geometry
    localparam int H_TOTAL   = 800;
    localparam int V_TOTAL   = 525;
    localparam int V_VISIBLE = 480;
    localparam int H_GROUPS  = 80;
    localparam int FB_WORDS  = H_GROUPS * V_VISIBLE;

    // Frame-clear engine state
    typedef enum logic {
        IDLE,
        CLEAR
    } clr_state_t;

    // Who owns the SRAM in a given decision cycle
    typedef enum logic [1:0] {
        NONE,
        DISP,
        DRAW,
        CLR
    } slot_t;

endpackage

// File: rtl/fb_clear_fsm.sv
// rtl/fb_clear_fsm.sv - frame-clear engine: state, address counter, busy and done
//
// Ports:
//   clk, reset   pixel clock, asynchronous active-high reset
//   clear_start  one-cycle pulse, starts a clear when idle
//   grant        arbiter granted the current clear write at addr
//   busy         high while clearing (registered)
//   done         one-cycle pulse after the last clear write (registered)
//   addr         address of the next clear write
module fb_clear_fsm
    import fb_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_start,
    input  logic              grant,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

    clr_state_t state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            addr  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state <= CLEAR;
                        addr  <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    // clear_start is ignored here; only granted writes advance
                    if (grant) begin
                        addr <= addr + ADDR_W'(1);
                        if (addr == LAST_ADDR) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fb_sram_arbiter.sv
// rtl/fb_sram_arbiter.sv - shares one framebuffer SRAM between display fetch, draw port and clear engine
//
// Ports:
//   clk, reset            pixel clock, asynchronous active-high reset
//   hcounter, vcounter    beam position from the VGA timing block
//   pixels                byte shown for the current 8-pixel group
//   draw_req/addr/data    held write request; draw_ack pulses when granted
//   clear_start           starts a full-frame clear; clear_busy / clear_done report it
//   sram_addr/wdata/we    registered SRAM pad outputs
//   sram_rdata            read data, valid one cycle after the address cycle
module fb_sram_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       hcounter,
    input  logic [9:0]        vcounter,
    output logic [7:0]        pixels,
    input  logic              draw_req,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [7:0]        draw_data,
    output logic              draw_ack,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_wdata,
    output logic              sram_we,
    input  logic [7:0]        sram_rdata
);

    localparam logic [9:0]        V_VIS       = 10'(V_VISIBLE);
    localparam logic [9:0]        V_LAST_VIS  = 10'(V_VISIBLE - 1);
    localparam logic [9:0]        V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [10:0]       H_LAST      = 11'(H_TOTAL - 1);
    localparam logic [10:0]       H_NEXT_SLOT = 11'(H_TOTAL - 8);
    // Slots for groups 0..78 of the current line lie below this hcounter;
    // group 79's byte is read one group earlier, so 632 ends the fetch.
    localparam logic [10:0]       H_FETCH_END = 11'(H_GROUPS * 8 - 8);
    localparam logic [10:0]       H_VIS_LAST  = 11'(H_GROUPS * 8 - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP   = ADDR_W'(H_GROUPS);

    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] next_base;
    logic [ADDR_W-1:0] disp_addr;
    logic [ADDR_W-1:0] clear_addr;
    logic [7:0]        group;
    logic [7:0]        shadow;
    logic              rd_p1;
    logic              rd_p2;
    logic              disp_cur;
    logic              disp_next;
    logic              next_vis;
    logic              clr_grant;
    slot_t             owner;

    assign group = hcounter[10:3];

    always_comb begin
        next_vis  = (vcounter < V_LAST_VIS) || (vcounter == V_LAST);
        disp_cur  = (vcounter < V_VIS) && (hcounter[2:0] == 3'd0) && (hcounter < H_FETCH_END);
        disp_next = (hcounter == H_NEXT_SLOT) && next_vis;
        // line_base advances by H_GROUPS per line, so the next line's base is one add away
        next_base = (vcounter == V_LAST) ? '0 : line_base + LINE_STEP;
        disp_addr = disp_next ? next_base : line_base + ADDR_W'(group) + ADDR_W'(1);

        owner = NONE;
        if (disp_cur || disp_next) begin
            owner = DISP;
        end else if (draw_req) begin
            owner = DRAW;
        end else if (clear_busy) begin
            owner = CLR;
        end
    end

    assign draw_ack  = (owner == DRAW);
    assign clr_grant = (owner == CLR);

    fb_clear_fsm #(
        .ADDR_W(ADDR_W)
    ) u_clear (
        .clk        (clk),
        .reset      (reset),
        .clear_start(clear_start),
        .grant      (clr_grant),
        .busy       (clear_busy),
        .done       (clear_done),
        .addr       (clear_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we    <= 1'b0;
            rd_p1      <= 1'b0;
            rd_p2      <= 1'b0;
            shadow     <= '0;
            pixels     <= '0;
            line_base  <= '0;
        end else begin
            case (owner)
                DISP: begin
                    sram_addr <= disp_addr;
                    sram_we   <= 1'b0;
                end
                DRAW: begin
                    sram_addr  <= draw_addr;
                    sram_wdata <= draw_data;
                    sram_we    <= 1'b1;
                end
                CLR: begin
                    sram_addr  <= clear_addr;
                    sram_wdata <= 8'h00;
                    sram_we    <= 1'b1;
                end
                default: begin
                    sram_we <= 1'b0;
                end
            endcase

            // Decision -> address on pads -> data on sram_rdata -> shadow
            rd_p1 <= (owner == DISP);
            rd_p2 <= rd_p1;
            if (rd_p2) begin
                shadow <= sram_rdata;
            end

            if ((hcounter[2:0] == 3'd7) && (hcounter < H_FETCH_END)) begin
                pixels <= shadow;
            end else if ((hcounter == H_LAST) && next_vis) begin
                pixels <= shadow;
            end else if (hcounter == H_VIS_LAST) begin
                pixels <= 8'h00;
            end

            if (hcounter == H_LAST) begin
                if (vcounter < V_LAST_VIS) begin
                    line_base <= line_base + LINE_STEP;
                end else if (vcounter == V_LAST) begin
                    line_base <= '0;
                end
            end
        end
    end

endmodule
